// File: rtl/avalon_mm_ram_agent.sv
// avalon_mm_ram_agent: word-organised RAM on the agent side of an Avalon-MM
// read/write port, with programmable read latency and write wait-states.
// One transaction outstanding at a time. Memory is not reset.
// Optional feature macro: AVALON_MM_RAM_AGENT_ERR_EN adds a sticky err output.
module avalon_mm_ram_agent #(
  parameter int unsigned WORDS        = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WRITE_WAIT   = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] host_to_agent,
  output logic [31:0] agent_to_host,
  output logic        waitrequest,
  output logic        readdatavalid
`ifdef AVALON_MM_RAM_AGENT_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [32:0] SPAN    = 33'(WORDS) << 2;
  localparam logic [3:0]  RL_LOAD = 4'(READ_LATENCY - 2);
  localparam logic [3:0]  WW_LOAD = 4'(WRITE_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_READ_RESP,
    ST_WRITE_WAIT
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   rd_idx;
  logic            rd_hit;

  logic [31:0]     mem [WORDS];

  logic [31:0]     offset;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic            commit;
  logic            mem_we;

  // Address decode relative to the window base.
  always_comb begin
    offset   = address - BASE_ADDR;
    in_range = ({1'b0, offset} < SPAN);
    idx      = offset[AW+1:2];
  end

  // Handshake decode: waitrequest and the write-commit strobe.
  always_comb begin
    waitrequest = 1'b0;
    commit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (write) begin
          if (WRITE_WAIT == 0) commit = 1'b1;
          else                 waitrequest = 1'b1;
        end
      end
      ST_READ_WAIT,
      ST_READ_RESP:  waitrequest = 1'b1;
      ST_WRITE_WAIT: begin
        waitrequest = (cnt != 4'd0);
        commit      = write && (cnt == 4'd0);
      end
      default: waitrequest = 1'b0;
    endcase
    mem_we = commit && in_range && rst;
  end

  // Byte-lane write into the storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[idx][8*i +: 8] <= host_to_agent[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered read response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      rd_idx        <= '0;
      rd_hit        <= 1'b0;
      readdatavalid <= 1'b0;
      agent_to_host <= 32'd0;
    end else begin
      readdatavalid <= 1'b0;
      agent_to_host <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (write) begin
            if (WRITE_WAIT != 0) begin
              state <= ST_WRITE_WAIT;
              cnt   <= WW_LOAD;
            end
          end else if (read) begin
            rd_idx <= idx;
            rd_hit <= in_range;
            if (READ_LATENCY == 1) begin
              state         <= ST_READ_RESP;
              readdatavalid <= 1'b1;
              agent_to_host <= in_range ? mem[idx] : 32'd0;
            end else begin
              state <= ST_READ_WAIT;
              cnt   <= RL_LOAD;
            end
          end
        end
        ST_READ_WAIT: begin
          if (cnt == 4'd0) begin
            state         <= ST_READ_RESP;
            readdatavalid <= 1'b1;
            agent_to_host <= rd_hit ? mem[rd_idx] : 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_READ_RESP: state <= ST_IDLE;
        ST_WRITE_WAIT: begin
          if (!write || cnt == 4'd0) state <= ST_IDLE;
          else                       cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AVALON_MM_RAM_AGENT_ERR_EN
  logic err_set;

  // Error events: out-of-range accepted access, read+write collision, dropped write.
  always_comb begin
    err_set = ((state == ST_IDLE) && read && !write && !in_range)
           || (commit && !in_range)
           || ((state == ST_IDLE) && read && write)
           || ((state == ST_WRITE_WAIT) && !write);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
      $display("%0t avalon_mm_ram_agent err: address=%h", $time, address);
    end
  end
`endif

endmodule
